// File: rtl/layer_train_sequencer.sv
// Training-pass sequencer: per sample FETCH/LOAD/FWD/SETTLE/LRN/STEP over N samples x E epochs.
// Define LAYER_SEQ_ERRCNT_EN to add per-epoch miss counting and early stop on a perfect epoch.
module layer_train_sequencer #(
  parameter int AW = 8,
  parameter int EW = 8,
  parameter int SW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] num_samples,
  input  logic [EW-1:0] num_epochs,
  input  logic [SW-1:0] settle_cycles,
`ifdef LAYER_SEQ_ERRCNT_EN
  input  logic          sample_ok,
  output logic [AW-1:0] epoch_errors,
`endif
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          sample_rd,
  output logic [AW-1:0] sample_addr,
  output logic          valid,
  output logic          learn,
  output logic [EW-1:0] epoch
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    FWD    = 3'd3,
    SETTLE = 3'd4,
    LRN    = 3'd5,
    STEP   = 3'd6,
    DONE   = 3'd7
  } state_t;

  localparam logic [AW-1:0] ONE_A = 1;
  localparam logic [EW-1:0] ONE_E = 1;
  localparam logic [SW-1:0] ONE_S = 1;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [EW-1:0] epoch_q, epoch_d;
  logic [AW-1:0] ns_q, ns_d;
  logic [EW-1:0] ne_q, ne_d;
  logic [SW-1:0] st_q, st_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          ready_q, busy_q, done_q, rd_q, valid_q, learn_q;
  logic          finish_run;
`ifdef LAYER_SEQ_ERRCNT_EN
  logic [AW-1:0] miss_q, miss_d;
  logic [AW-1:0] errs_q, errs_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    epoch_d    = epoch_q;
    ns_d       = ns_q;
    ne_d       = ne_q;
    st_d       = st_q;
    cnt_d      = cnt_q;
    finish_run = 1'b0;
`ifdef LAYER_SEQ_ERRCNT_EN
    miss_d     = miss_q;
    errs_d     = errs_q;
`endif
    // Abort wins everywhere except IDLE; counters freeze where they are.
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ns_d    = num_samples;
            ne_d    = num_epochs;
            st_d    = settle_cycles;
            addr_d  = '0;
            epoch_d = '0;
`ifdef LAYER_SEQ_ERRCNT_EN
            miss_d  = '0;
`endif
            state_d = (num_samples == '0 || num_epochs == '0) ? DONE : FETCH;
          end
        end
        FETCH: state_d = LOAD;
        LOAD:  state_d = FWD;
        FWD: begin
          cnt_d   = st_q;
          state_d = (st_q != '0) ? SETTLE : LRN;
        end
        SETTLE: begin
          if (cnt_q <= ONE_S) state_d = LRN;
          else                cnt_d   = cnt_q - ONE_S;
        end
        LRN: begin
`ifdef LAYER_SEQ_ERRCNT_EN
          if (!sample_ok) miss_d = miss_q + ONE_A;
`endif
          state_d = STEP;
        end
        STEP: begin
          if (addr_q != ns_q - ONE_A) begin
            addr_d  = addr_q + ONE_A;
            state_d = FETCH;
          end else begin
            addr_d     = '0;
            epoch_d    = epoch_q + ONE_E;
            finish_run = (epoch_d == ne_q);
`ifdef LAYER_SEQ_ERRCNT_EN
            errs_d = miss_q;
            miss_d = '0;
            if (miss_q == '0) finish_run = 1'b1;
`endif
            state_d = finish_run ? DONE : FETCH;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state and registered strobes, decoded from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      epoch_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      learn_q <= 1'b0;
`ifdef LAYER_SEQ_ERRCNT_EN
      miss_q  <= '0;
      errs_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      epoch_q <= epoch_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      rd_q    <= (state_d == FETCH);
      valid_q <= (state_d == FWD) || (state_d == LRN);
      learn_q <= (state_d == LRN);
`ifdef LAYER_SEQ_ERRCNT_EN
      miss_q  <= miss_d;
      errs_q  <= errs_d;
`endif
    end
  end

  // Latched operands and settle counter carry no reset; they are always loaded before use.
  always_ff @(posedge clock) begin
    ns_q  <= ns_d;
    ne_q  <= ne_d;
    st_q  <= st_d;
    cnt_q <= cnt_d;
  end

  assign ready       = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sample_rd   = rd_q;
  assign valid       = valid_q;
  assign learn       = learn_q;
  assign sample_addr = addr_q;
  assign epoch       = epoch_q;
`ifdef LAYER_SEQ_ERRCNT_EN
  assign epoch_errors = errs_q;
`endif

endmodule

// File: tb/tb_layer_train_sequencer.sv
// Scoreboard bench for layer_train_sequencer: expected strobe events are queued per run and
// popped as the sequencer emits sample_rd / valid strobes.
module tb_layer_train_sequencer;
  localparam int AW = 8;
  localparam int EW = 8;
  localparam int SW = 4;

  logic          clock = 1'b0;
  logic          reset, start, abort;
  logic [AW-1:0] num_samples;
  logic [EW-1:0] num_epochs;
  logic [SW-1:0] settle_cycles;
  logic          ready, busy, done, sample_rd, valid, learn;
  logic [AW-1:0] sample_addr;
  logic [EW-1:0] epoch;
`ifdef LAYER_SEQ_ERRCNT_EN
  logic          sample_ok;
  logic [AW-1:0] epoch_errors;
`endif

  always #5 clock = ~clock;

  layer_train_sequencer #(.AW(AW), .EW(EW), .SW(SW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .num_samples(num_samples), .num_epochs(num_epochs), .settle_cycles(settle_cycles),
`ifdef LAYER_SEQ_ERRCNT_EN
    .sample_ok(sample_ok), .epoch_errors(epoch_errors),
`endif
    .ready(ready), .busy(busy), .done(done), .sample_rd(sample_rd),
    .sample_addr(sample_addr), .valid(valid), .learn(learn), .epoch(epoch)
  );

  // kind: 0 = sample_rd, 1 = forward valid, 2 = valid+learn
  typedef struct {
    int cyc;
    int kind;
    int addr;
    int ep;
    bit ok;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  errs_seen[0:15];
  int  final_errs;

  // Reference model: cycle offsets counted from the start edge.
  task automatic push_model(input int n, input int e, input int s, input int bad_ep,
                            input int bad_addr, input bit errmode, output int nsamp);
    int misses;
    nsamp = 0;
    for (int ep = 0; ep < e; ep++) begin
      misses = 0;
      for (int a = 0; a < n; a++) begin
        int  base;
        bit  ok;
        base = 1 + nsamp * (5 + s);
        ok   = errmode && !(ep == bad_ep && a == bad_addr);
        if (!ok) misses++;
        exp_q.push_back('{base,         0, a, ep, ok});
        exp_q.push_back('{base + 2,     1, a, ep, ok});
        exp_q.push_back('{base + 3 + s, 2, a, ep, ok});
        nsamp++;
      end
`ifdef LAYER_SEQ_ERRCNT_EN
      if (misses == 0) break;
`endif
    end
  endtask

  // Starts a run and scores strobes until done, abort, or budget. Leaves time in the
  // done cycle (done_cyc > 0) or in the cycle after the abort edge.
  task automatic run_seq(input int n, input int e, input int s, input int budget,
                         input int abort_at, input int restart_at, output int done_cyc);
    int  kind;
    ev_t ev;
    bit  stop;
    num_samples   = n[AW-1:0];
    num_epochs    = e[EW-1:0];
    settle_cycles = s[SW-1:0];
    start = 1'b1;
    @(posedge clock); #1;
    start    = 1'b0;
    done_cyc = -1;
    stop     = 1'b0;
    for (int cyc = 1; cyc <= budget && !stop; cyc++) begin
      if (sample_rd || valid) begin
        kind = sample_rd ? 0 : (learn ? 2 : 1);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL extra_strobe: cyc=%0d kind=%0d addr=%0d, required no strobe", cyc, kind, sample_addr);
        end else begin
          ev = exp_q.pop_front();
          if (cyc !== ev.cyc || kind !== ev.kind || int'(sample_addr) !== ev.addr || int'(epoch) !== ev.ep) begin
            n_bad++;
            $display("FAIL strobe: got cyc=%0d kind=%0d addr=%0d ep=%0d, required cyc=%0d kind=%0d addr=%0d ep=%0d",
                     cyc, kind, sample_addr, epoch, ev.cyc, ev.kind, ev.addr, ev.ep);
          end
`ifdef LAYER_SEQ_ERRCNT_EN
          if (kind == 2) sample_ok = ev.ok;
          if (kind == 1 && ev.addr == 0 && ev.ep > 0 && ev.ep <= 16) errs_seen[ev.ep-1] = int'(epoch_errors);
`endif
        end
      end
      if (done) begin
        done_cyc = cyc;
`ifdef LAYER_SEQ_ERRCNT_EN
        final_errs = int'(epoch_errors);
`endif
        stop = 1'b1;
      end else begin
        if (cyc == abort_at) abort = 1'b1;
        if (cyc == restart_at) begin
          start = 1'b1;
          num_samples = 1; num_epochs = 1; settle_cycles = 0;
        end
        @(posedge clock); #1;
        start = 1'b0;
        abort = 1'b0;
        if (cyc == abort_at) stop = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    int dones;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    n_cmp++;
    if ({ready, busy, done, sample_rd, valid, learn} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, required 100000", {ready, busy, done, sample_rd, valid, learn});
    end
    n_cmp++;
    if (epoch !== '0 || sample_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_counters: got epoch=%0d addr=%0d, required 0/0", epoch, sample_addr);
    end
    // Reset mid-run: back to IDLE on the next edge, no done afterwards.
    num_samples = 2; num_epochs = 2; settle_cycles = 1;
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (6) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    n_cmp++;
    if ({ready, busy, done, valid} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_midrun: got ready/busy/done/valid=%b, required 1000", {ready, busy, done, valid});
    end
    dones = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (done || valid) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL reset_midrun_quiet: got %0d done/valid cycles, required 0", dones);
    end
  endtask

  task automatic test_basic();
    int ns, dc;
    push_model(3, 2, 2, -1, -1, 1'b0, ns);
    run_seq(3, 2, 2, 100, -1, -1, dc);
    n_cmp++;
    if (dc !== 43) begin
      n_bad++;
      $display("FAIL basic_done_cycle: got %0d, required 43", dc);
    end
    n_cmp++;
    if (epoch !== 8'd2) begin
      n_bad++;
      $display("FAIL basic_epoch: got %0d, required 2", epoch);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL basic_missing_strobes: got %0d left, required 0", exp_q.size());
    end
    exp_q.delete();
    @(posedge clock); #1;
    n_cmp++;
    if ({ready, done} !== 2'b10) begin
      n_bad++;
      $display("FAIL basic_return_idle: got ready/done=%b, required 10", {ready, done});
    end
  endtask

  task automatic test_back_to_back();
    int ns, dc;
    push_model(4, 1, 0, -1, -1, 1'b0, ns);
    run_seq(4, 1, 0, 100, -1, 5, dc);
    n_cmp++;
    if (dc !== 21) begin
      n_bad++;
      $display("FAIL s0_done_cycle: got %0d, required 21", dc);
    end
    n_cmp++;
    if (exp_q.size() !== 0 || epoch !== 8'd1) begin
      n_bad++;
      $display("FAIL s0_end_state: got left=%0d epoch=%0d, required 0/1", exp_q.size(), epoch);
    end
    exp_q.delete();
    @(posedge clock); #1;
  endtask

  task automatic test_abort();
    int ns, dc, noise;
    push_model(3, 1, 3, -1, -1, 1'b0, ns);
    run_seq(3, 1, 3, 100, 12, -1, dc);
    n_cmp++;
    if (dc !== -1 || ready !== 1'b1 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: got done_cyc=%0d ready=%b valid=%b, required -1/1/0", dc, ready, valid);
    end
    n_cmp++;
    if (sample_addr !== 8'd1 || epoch !== 8'd0) begin
      n_bad++;
      $display("FAIL abort_freeze: got addr=%0d epoch=%0d, required 1/0", sample_addr, epoch);
    end
    n_cmp++;
    if (exp_q.size() !== 4) begin
      n_bad++;
      $display("FAIL abort_strobes_seen: got %0d pending, required 4", exp_q.size());
    end
    exp_q.delete();
    noise = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (done || valid || sample_rd || busy) noise++;
    end
    n_cmp++;
    if (noise !== 0) begin
      n_bad++;
      $display("FAIL abort_quiet: got %0d active cycles, required 0", noise);
    end
  endtask

  task automatic test_zero();
    int ns, dc;
    push_model(0, 5, 1, -1, -1, 1'b0, ns);
    run_seq(0, 5, 1, 20, -1, -1, dc);
    n_cmp++;
    if (dc !== 1 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL zero_n: got done_cyc=%0d pending=%0d, required 1/0", dc, exp_q.size());
    end
    @(posedge clock); #1;
    push_model(7, 0, 1, -1, -1, 1'b0, ns);
    run_seq(7, 0, 1, 20, -1, -1, dc);
    n_cmp++;
    if (dc !== 1 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL zero_e: got done_cyc=%0d pending=%0d, required 1/0", dc, exp_q.size());
    end
    exp_q.delete();
    @(posedge clock); #1;
  endtask

`ifdef LAYER_SEQ_ERRCNT_EN
  task automatic test_errcnt();
    int ns, dc;
    push_model(4, 10, 1, 0, 2, 1'b1, ns);
    run_seq(4, 10, 1, 200, -1, -1, dc);
    n_cmp++;
    if (dc !== 1 + ns * 6 || ns !== 8) begin
      n_bad++;
      $display("FAIL err_done_cycle: got %0d, required %0d", dc, 1 + 8 * 6);
    end
    n_cmp++;
    if (errs_seen[0] !== 1 || final_errs !== 0) begin
      n_bad++;
      $display("FAIL err_counts: got ep0=%0d ep1=%0d, required 1/0", errs_seen[0], final_errs);
    end
    n_cmp++;
    if (epoch !== 8'd2) begin
      n_bad++;
      $display("FAIL err_epoch: got %0d, required 2", epoch);
    end
    exp_q.delete();
    sample_ok = 1'b0;
    @(posedge clock); #1;
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    num_samples = '0; num_epochs = '0; settle_cycles = '0;
    final_errs = -1;
    for (int i = 0; i < 16; i++) errs_seen[i] = -1;
`ifdef LAYER_SEQ_ERRCNT_EN
    sample_ok = 1'b0;
`endif
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_zero();
`ifdef LAYER_SEQ_ERRCNT_EN
    test_errcnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
